// File: rtl/jb_prach_tdm_pkt_buf.sv
// PRACH TDM packet buffer: sequence-checks the antenna-interleaved stream from the p2s stage,
// buffers it in a FIFO and re-emits it as an AXI-stream with tlast every PKT_GROUPS antenna groups.
module jb_prach_tdm_pkt_buf #(
  parameter int N_ANTENNAS = 4,
  parameter int PRECISION  = 16,
  parameter int USR_ID_BW  = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_GROUPS = 64
) (
  input  logic                           clk_4x,
  input  logic                           resetn_4x,
  input  logic                           clk_en,
  input  logic                           tvalid_in,
  input  logic [2*PRECISION-1:0]         tdata_in,
  input  logic [USR_ID_BW-1:0]           tuser_in,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [2*PRECISION-1:0]         m_tdata,
  output logic [USR_ID_BW-1:0]           m_tuser,
  output logic                           m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow,
  output logic                           seq_err,
  input  logic                           err_clear
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (PKT_GROUPS > 1) ? $clog2(PKT_GROUPS) : 1;
  localparam logic [USR_ID_BW:0]   N_ANT    = (USR_ID_BW+1)'(N_ANTENNAS);
  localparam logic [USR_ID_BW-1:0] LAST_ANT = USR_ID_BW'(N_ANTENNAS - 1);
  localparam logic [GW-1:0]        LAST_GRP = GW'(PKT_GROUPS - 1);
  localparam logic [LW-1:0]        DEPTH    = LW'(FIFO_DEPTH);

  typedef struct packed {
    logic                   last;
    logic [USR_ID_BW-1:0]   user;
    logic [2*PRECISION-1:0] data;
  } beat_t;

  beat_t                mem [FIFO_DEPTH];
  beat_t                beat_in;
  beat_t                out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        mem_cnt_q, mem_cnt_d, level;
  logic [USR_ID_BW-1:0] exp_ant_q, exp_ant_d;
  logic [GW-1:0]        grp_cnt_q, grp_cnt_d;
  logic                 overflow_q, overflow_d, seq_err_q, seq_err_d;
  logic                 accept, in_range, is_last_ant, pop, space, wr, rd;

  always_comb begin
    accept      = clk_en & tvalid_in;
    in_range    = {1'b0, tuser_in} < N_ANT;
    is_last_ant = (tuser_in == LAST_ANT);
    pop         = out_vld_q & m_tready;
    // Level includes the output register so "full" means FIFO_DEPTH beats in flight overall.
    level       = mem_cnt_q + {{AW{1'b0}}, out_vld_q};
    space       = (level < DEPTH) | pop;
    wr          = accept & in_range & space;
    rd          = (mem_cnt_q != '0) & (~out_vld_q | pop);

    beat_in.last = is_last_ant & (grp_cnt_q == LAST_GRP);
    beat_in.user = tuser_in;
    beat_in.data = tdata_in;

    // Checker resyncs to whatever valid index arrives; out-of-range indices leave timing untouched.
    exp_ant_d = exp_ant_q;
    grp_cnt_d = grp_cnt_q;
    if (accept && in_range) begin
      exp_ant_d = is_last_ant ? '0 : tuser_in + 1'b1;
      if (is_last_ant)
        grp_cnt_d = (grp_cnt_q == LAST_GRP) ? '0 : grp_cnt_q + 1'b1;
    end

    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({wr, rd})
      2'b10:   mem_cnt_d = mem_cnt_q + 1'b1;
      2'b01:   mem_cnt_d = mem_cnt_q - 1'b1;
      default: mem_cnt_d = mem_cnt_q;
    endcase

    // Output register only reloads when empty or popped, so a stalled beat stays put.
    out_d     = rd ? mem[rd_ptr_q] : out_q;
    out_vld_d = rd | (out_vld_q & ~pop);

    overflow_d = (overflow_q & ~err_clear) | (accept & in_range & ~space);
    seq_err_d  = (seq_err_q & ~err_clear) | (accept & (tuser_in != exp_ant_q));
  end

  always_ff @(posedge clk_4x) begin
    if (wr) mem[wr_ptr_q] <= beat_in;
  end

  always_ff @(posedge clk_4x or negedge resetn_4x) begin
    if (!resetn_4x) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      exp_ant_q  <= '0;
      grp_cnt_q  <= '0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      exp_ant_q  <= exp_ant_d;
      grp_cnt_q  <= grp_cnt_d;
      overflow_q <= overflow_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign m_tvalid   = out_vld_q;
  assign m_tdata    = out_q.data;
  assign m_tuser    = out_q.user;
  assign m_tlast    = out_q.last;
  assign fifo_level = level;
  assign overflow   = overflow_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_jb_prach_tdm_pkt_buf.sv
// Directed bench for jb_prach_tdm_pkt_buf: framing, sequence check, overflow, full push/pop,
// clk_en/backpressure stability, err_clear and mid-packet reset.
module tb_jb_prach_tdm_pkt_buf;
  logic        clk_4x = 1'b0;
  logic        resetn_4x = 1'b0;
  logic        clk_en = 1'b0;
  logic        tvalid_in = 1'b0;
  logic [31:0] tdata_in = '0;
  logic [1:0]  tuser_in = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] m_tdata;
  logic [1:0]  m_tuser;
  logic        m_tlast;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        seq_err;
  logic        err_clear = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_d [1024];
  logic [1:0]  cap_u [1024];
  logic        cap_l [1024];
  int          cap_n = 0;

  jb_prach_tdm_pkt_buf #(
    .N_ANTENNAS(4), .PRECISION(16), .USR_ID_BW(2), .FIFO_DEPTH(16), .PKT_GROUPS(2)
  ) dut (
    .clk_4x(clk_4x), .resetn_4x(resetn_4x), .clk_en(clk_en), .tvalid_in(tvalid_in),
    .tdata_in(tdata_in), .tuser_in(tuser_in), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .fifo_level(fifo_level),
    .overflow(overflow), .seq_err(seq_err), .err_clear(err_clear)
  );

  always #5 clk_4x = ~clk_4x;

  // Inputs change only at posedge+1, so the negedge view equals what the next posedge sees.
  always @(negedge clk_4x) begin
    if (resetn_4x && m_tvalid && m_tready && cap_n < 1024) begin
      cap_d[cap_n] = m_tdata;
      cap_u[cap_n] = m_tuser;
      cap_l[cap_n] = m_tlast;
      cap_n++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic drive(input logic ce, input logic v, input logic [31:0] d, input logic [1:0] u);
    clk_en = ce; tvalid_in = v; tdata_in = d; tuser_in = u;
    @(posedge clk_4x); #1;
  endtask

  task automatic idle(input int n);
    clk_en = 1'b0; tvalid_in = 1'b0;
    repeat (n) begin @(posedge clk_4x); #1; end
  endtask

  task automatic reset_dut();
    clk_en = 0; tvalid_in = 0; m_tready = 0; err_clear = 0;
    resetn_4x = 1'b0;
    repeat (2) @(posedge clk_4x);
    #1 resetn_4x = 1'b1;
    @(posedge clk_4x); #1;
  endtask

  task automatic wait_beats(input int base, input int n, input string nm);
    int t = 0;
    while (cap_n - base < n && t < 200) begin @(posedge clk_4x); #1; t++; end
    repeat (4) begin @(posedge clk_4x); #1; end
    checks++;
    if (cap_n - base != n) begin
      errors++; $display("FAIL %s beat_count got %0d want %0d", nm, cap_n - base, n);
    end
  endtask

  task automatic test_reset();
    resetn_4x = 1'b0; #3;
    checks++;
    if ({m_tvalid, m_tlast, overflow, seq_err, m_tuser, m_tdata, fifo_level} !== '0) begin
      errors++; $display("FAIL reset_during outputs not zero: v=%b d=%h lvl=%0d", m_tvalid, m_tdata, fifo_level);
    end
    reset_dut();
    checks++;
    if ({m_tvalid, m_tlast, overflow, seq_err, m_tuser, m_tdata, fifo_level} !== '0) begin
      errors++; $display("FAIL reset_after outputs not zero: v=%b d=%h lvl=%0d", m_tvalid, m_tdata, fifo_level);
    end
  endtask

  task automatic test_latency();
    reset_dut();
    drive(1, 1, 32'h0000_00A5, 2'd0);
    idle(0);
    checks++;
    if (m_tvalid !== 1'b0 || fifo_level !== 5'd1) begin
      errors++; $display("FAIL latency_k got v=%b lvl=%0d want v=0 lvl=1", m_tvalid, fifo_level);
    end
    idle(1);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0000_00A5 || fifo_level !== 5'd1) begin
      errors++; $display("FAIL latency_k1 got v=%b d=%h lvl=%0d want v=1 d=a5 lvl=1", m_tvalid, m_tdata, fifo_level);
    end
  endtask

  task automatic test_seq_framing();
    int base;
    reset_dut();
    m_tready = 1; base = cap_n;
    for (int i = 0; i < 8; i++) drive(1, 1, 32'(100 + i), 2'(i % 4));
    idle(0);
    wait_beats(base, 8, "seq_framing");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_d[base+i] !== 32'(100 + i) || cap_u[base+i] !== 2'(i % 4) || cap_l[base+i] !== (i == 7)) begin
        errors++; $display("FAIL seq_beat%0d got d=%0d u=%0d l=%b want d=%0d u=%0d l=%b",
                           i, cap_d[base+i], cap_u[base+i], cap_l[base+i], 100 + i, i % 4, i == 7);
      end
    end
    checks++;
    if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_err_clean got %b want 0", seq_err); end
  endtask

  task automatic test_index_skip();
    int base;
    logic [1:0] us [4];
    us[0] = 2'd0; us[1] = 2'd1; us[2] = 2'd3; us[3] = 2'd0;
    reset_dut();
    m_tready = 1; base = cap_n;
    drive(1, 1, 32'd10, us[0]);
    drive(1, 1, 32'd11, us[1]);
    checks++;
    if (seq_err !== 1'b0) begin errors++; $display("FAIL skip_before got %b want 0", seq_err); end
    drive(1, 1, 32'd12, us[2]);
    checks++;
    if (seq_err !== 1'b1) begin errors++; $display("FAIL skip_flag got %b want 1", seq_err); end
    // Clearing alongside the 4th beat shows that beat raises no new error.
    err_clear = 1;
    drive(1, 1, 32'd13, us[3]);
    err_clear = 0; idle(0);
    checks++;
    if (seq_err !== 1'b0) begin errors++; $display("FAIL skip_resync got %b want 0", seq_err); end
    wait_beats(base, 4, "index_skip");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_d[base+i] !== 32'(10 + i) || cap_u[base+i] !== us[i] || cap_l[base+i] !== 1'b0) begin
        errors++; $display("FAIL skip_beat%0d got d=%0d u=%0d l=%b want d=%0d u=%0d l=0",
                           i, cap_d[base+i], cap_u[base+i], cap_l[base+i], 10 + i, us[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int base;
    reset_dut();
    for (int i = 1; i <= 20; i++) begin
      drive(1, 1, 32'(i), 2'((i - 1) % 4));
      if (i == 16) begin
        checks++;
        if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_at16 got lvl=%0d ovf=%b want 16 0", fifo_level, overflow);
        end
      end
    end
    idle(1);
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_at20 got lvl=%0d ovf=%b want 16 1", fifo_level, overflow);
    end
    base = cap_n; m_tready = 1;
    wait_beats(base, 16, "overflow_drain");
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_d[base+i] !== 32'(i + 1) || cap_l[base+i] !== (i % 8 == 7)) begin
        errors++; $display("FAIL ovf_beat%0d got d=%0d l=%b want d=%0d l=%b",
                           i, cap_d[base+i], cap_l[base+i], i + 1, i % 8 == 7);
      end
    end
    checks++;
    if (fifo_level !== 5'd0) begin errors++; $display("FAIL ovf_empty got lvl=%0d want 0", fifo_level); end
  endtask

  task automatic test_full_push_pop();
    int base;
    reset_dut();
    for (int i = 1; i <= 16; i++) drive(1, 1, 32'(i), 2'((i - 1) % 4));
    idle(1);
    checks++;
    if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_fill got lvl=%0d want 16", fifo_level); end
    base = cap_n; m_tready = 1;
    drive(1, 1, 32'h55, 2'd0);
    m_tready = 0; idle(0);
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_pushpop got lvl=%0d ovf=%b want 16 0", fifo_level, overflow);
    end
    m_tready = 1;
    wait_beats(base, 17, "full_pushpop_drain");
    checks++;
    if (cap_d[base] !== 32'd1 || cap_d[base+15] !== 32'd16 || cap_d[base+16] !== 32'h55) begin
      errors++; $display("FAIL full_order got %0d,%0d,%h want 1,16,55", cap_d[base], cap_d[base+15], cap_d[base+16]);
    end
  endtask

  task automatic test_clken_backpressure();
    int base, cnt;
    logic prev_stall;
    logic [34:0] prev_out;
    logic ce, r;
    reset_dut();
    base = cap_n; cnt = 0; prev_stall = 0; prev_out = '0;
    for (int i = 0; i < 32; i++) begin
      ce = (i % 2 == 0);
      r = 1'($urandom_range(1, 0));
      if (prev_stall) begin
        checks++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, prev_out}) begin
          errors++; $display("FAIL stall_hold cyc%0d got v=%b d=%h want v=1 d=%h", i, m_tvalid, m_tdata, prev_out[31:0]);
        end
      end
      prev_stall = m_tvalid & ~r;
      prev_out   = {m_tlast, m_tuser, m_tdata};
      m_tready   = r;
      if (ce) begin drive(1, 1, 32'(200 + cnt), 2'(cnt % 4)); cnt++; end
      else drive(0, 1, 32'hDEAD, 2'd2);
    end
    idle(0); m_tready = 1;
    wait_beats(base, 16, "clken_bp");
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_d[base+i] !== 32'(200 + i) || cap_u[base+i] !== 2'(i % 4)) begin
        errors++; $display("FAIL clken_beat%0d got d=%0d u=%0d want d=%0d u=%0d",
                           i, cap_d[base+i], cap_u[base+i], 200 + i, i % 4);
      end
    end
    checks++;
    if (seq_err !== 1'b0) begin errors++; $display("FAIL clken_seq got %b want 0", seq_err); end
  endtask

  task automatic test_err_clear_reset();
    int base;
    reset_dut();
    for (int i = 0; i < 17; i++) drive(1, 1, 32'(i + 1), 2'((i + 1) % 4));
    idle(1);
    checks++;
    if (overflow !== 1'b1 || seq_err !== 1'b1) begin
      errors++; $display("FAIL sticky_set got ovf=%b seq=%b want 1 1", overflow, seq_err);
    end
    err_clear = 1; @(posedge clk_4x); #1; err_clear = 0;
    checks++;
    if (overflow !== 1'b0 || seq_err !== 1'b0) begin
      errors++; $display("FAIL err_clear got ovf=%b seq=%b want 0 0", overflow, seq_err);
    end
    // Move into the middle of a packet (group 1) before resetting.
    m_tready = 1;
    drive(1, 1, 32'd90, 2'd2);
    drive(1, 1, 32'd91, 2'd3);
    idle(0);
    #2 resetn_4x = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, m_tlast, overflow, seq_err, m_tuser, m_tdata, fifo_level} !== '0) begin
      errors++; $display("FAIL midpkt_reset got v=%b d=%h lvl=%0d want all 0", m_tvalid, m_tdata, fifo_level);
    end
    @(posedge clk_4x); #1 resetn_4x = 1'b1;
    base = cap_n; m_tready = 1;
    for (int i = 0; i < 8; i++) drive(1, 1, 32'(300 + i), 2'(i % 4));
    idle(0);
    wait_beats(base, 8, "post_reset");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_d[base+i] !== 32'(300 + i) || cap_l[base+i] !== (i == 7)) begin
        errors++; $display("FAIL post_reset_beat%0d got d=%0d l=%b want d=%0d l=%b",
                           i, cap_d[base+i], cap_l[base+i], 300 + i, i == 7);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_seq_framing();
    test_index_skip();
    test_overflow();
    test_full_push_pop();
    test_clken_backpressure();
    test_err_clear_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
